// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - Default widths for writeback data, register address and conflict counter.
//   - gnt_t names the last requester that was granted.
//   - Reset constants for the output stage and the round-robin pointer.
package wb_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_AW_DEF = 3;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_M = 1'b1
  } gnt_t;

  // M is "last granted" out of reset so that A wins the first tie.
  localparam gnt_t LAST_GNT_RST  = GNT_M;
  localparam logic RST_REG_WRITE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   req      in   [0] = ALU requester, [1] = load requester
//   en       in   grants allowed this cycle (low during stall or reset)
//   gnt      out  one-hot grant, combinational from req/en/last_gnt
//   last_gnt out  requester granted on the most recent transfer
module rr_arb2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output gnt_t       last_gnt
);

  gnt_t last_gnt_q, last_gnt_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Tie goes to whoever did not win last time.
        2'b11:   gnt = (last_gnt_q == GNT_M) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves only when a grant turns into a transfer; a grant here always does.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[0]) begin
      last_gnt_d = GNT_A;
    end else if (gnt[1]) begin
      last_gnt_d = GNT_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q <= LAST_GNT_RST;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign last_gnt = last_gnt_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port between the ALU (A)
// and memory-load (M) requesters. One write per cycle, round-robin on ties, one cycle
// of latency through a registered output stage.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   a_valid/a_reg/a_data/a_ready  ALU writeback handshake
//   m_valid/m_reg/m_data/m_ready  load writeback handshake
//   stall                         blocks all grants while high
//   write_reg/write_data/reg_write  register-file write port
//   pend_mask                     one-hot of write_reg while reg_write is high
//   conflict_cnt                  saturating count of contended, unstalled cycles
// Build option: define WB_R0_DISCARD_EN to accept writes to register 0 but suppress
// them at the write port, making R0 behave as hard-wired.
module rf_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [REG_AW-1:0]        a_reg,
  input  logic [DATA_W-1:0]        a_data,
  output logic                     a_ready,
  input  logic                     m_valid,
  input  logic [REG_AW-1:0]        m_reg,
  input  logic [DATA_W-1:0]        m_data,
  output logic                     m_ready,
  input  logic                     stall,
  output logic [REG_AW-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  output logic                     reg_write,
  output logic [(1<<REG_AW)-1:0]   pend_mask,
  output logic [CNT_W-1:0]         conflict_cnt
);

  logic [1:0]        gnt;
  gnt_t              last_gnt;
  logic              transfer;
  logic [REG_AW-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Reset is folded into the enable so ready stays low while rst_n is low.
  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({m_valid, a_valid}),
    .en       (rst_n && !stall),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );

  assign a_ready  = gnt[0];
  assign m_ready  = gnt[1];
  assign transfer = a_ready || m_ready;

  always_comb begin
    sel_reg  = m_ready ? m_reg  : a_reg;
    sel_data = m_ready ? m_data : a_data;
  end

  always_comb begin
    reg_write_d  = transfer;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (transfer) begin
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
    end
`ifdef WB_R0_DISCARD_EN
    // Accepted and pointer-advancing, but never reaches the register file.
    if (transfer && (sel_reg == '0)) begin
      reg_write_d = 1'b0;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (a_valid && m_valid && !stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= RST_REG_WRITE;
      write_reg_q  <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (reg_write_q) begin
      pend_mask[write_reg_q] = 1'b1;
    end
  end

  assign reg_write    = reg_write_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign conflict_cnt = cnt_q;

  a_ready_onehot: assert property (@(posedge clk) !(a_ready && m_ready));
  a_ptr_tracks:   assert property (@(posedge clk) a_ready |=> (last_gnt == GNT_A));
  m_ptr_tracks:   assert property (@(posedge clk) m_ready |=> (last_gnt == GNT_M));

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 8x16 register file between two writeback requesters: ALU result (A) and memory load (M).
- Round-robin arbitration, one write per cycle, registered output stage driving the regfile write port.
- Outputs a pending-write mask for hazard/forwarding logic and a saturating conflict counter for performance visibility.
- Sits between the execute/memory stages and regfile.

Parameters:
- DATA_W, 16, writeback data width (matches regfile word).
- REG_AW, 3, register address width (8 registers).
- CNT_W, 8, width of the conflict counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- a_valid  in  1  ALU writeback request.
- a_reg  in  REG_AW  ALU destination register.
- a_data  in  DATA_W  ALU result.
- a_ready  out  1  ALU request accepted this cycle.
- m_valid  in  1  load writeback request.
- m_reg  in  REG_AW  load destination register.
- m_data  in  DATA_W  load data.
- m_ready  out  1  load request accepted this cycle.
- stall  in  1  hold: no grants while high.
- write_reg  out  REG_AW  to regfile write_reg.
- write_data  out  DATA_W  to regfile write_data.
- reg_write  out  1  to regfile reg_write.
- pend_mask  out  2**REG_AW  one-hot of write_reg while reg_write=1, else 0.
- conflict_cnt  out  CNT_W  cycles with both requests valid and stall=0; saturating.

Behaviour:
- Handshake:
  - Transfer occurs when x_valid && x_ready.
  - x_ready is combinational from the valids, stall and last_gnt; it never depends on x_data or x_reg.
  - Requesters hold valid/reg/data stable until accepted.
- Arbitration, evaluated only when stall=0:
  - Only A valid: grant A.
  - Only M valid: grant M.
  - Both valid: grant the requester not in last_gnt.
  - At most one ready per cycle.
  - last_gnt updates only on a transfer.
- State: last_gnt in {GNT_A, GNT_M}. Reset value is GNT_M, so A wins the first tie.
- Latency: 1 cycle. The granted reg/data appears on write_reg/write_data with reg_write=1 in the cycle after acceptance.
- No-transfer cycles (no grant, or stall=1): next cycle reg_write=0. write_reg and write_data hold their last values.
- Back-to-back grants give a write every cycle with no bubble.
- Same destination: A and M may target the same register in the same cycle. Order is resolved purely by round-robin; the later-written value persists in the regfile. No merging or dropping.
- conflict_cnt:
  - Increments on cycles with a_valid && m_valid && !stall.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset (rst_n=0 at a clock edge):
  - reg_write=0, write_reg=0, write_data=0, conflict_cnt=0, last_gnt=GNT_M.
  - a_ready=0 and m_ready=0 while rst_n=0.
  - A write accepted in the cycle before reset is discarded (reg_write is 0 the cycle after the reset edge).
- pend_mask is purely derived from the registered outputs, so it is 0 during and after reset.

Optional Feature:
- Macro: WB_R0_DISCARD_EN.
- Defined: a granted request with reg==0 is accepted normally (ready=1, round-robin pointer updates), but the next cycle keeps reg_write=0 and pend_mask=0. R0 behaves as hard-wired.
- Undefined: R0 writes are treated like any other register.

Decomposition:
- Package wb_pkg: DATA_W/REG_AW defaults, enum gnt_t {GNT_A, GNT_M}, reset constants.
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], en, clk, rst_n.
  - Outputs: gnt[1:0] and the last_gnt register.
- Top level: output register stage, R0 filter, counter.

Test Plan:
- Reset, then a_valid=1, a_reg=3, a_data=16'h1234 -> a_ready=1 same cycle; next cycle reg_write=1, write_reg=3, write_data=16'h1234, pend_mask=8'b0000_1000.
- Both valid for 4 cycles with A reg=1 and M reg=2 -> grants A,M,A,M; writes to regs 1,2,1,2 on consecutive cycles; conflict_cnt=4.
- Both valid with reg=5, A data=16'hAAAA, M data=16'h5555, first tie after reset -> A written, then M; final write_data=16'h5555 to reg 5.
- stall=1 with both valid for 3 cycles -> no ready, reg_write=0, conflict_cnt unchanged. Release stall -> normal round-robin resumes from the previous pointer.
- Hold both valid for 300 cycles -> conflict_cnt saturates at 255.
- Accept M (reg=4) then assert rst_n=0 next edge -> reg_write=0 and all outputs at reset values. With WB_R0_DISCARD_EN: a_reg=0 accepted, reg_write stays 0.
